lift_step_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-sample 5/3 lifting step.
- Performs one Le Gall 5/3 lifting operation per accepted sample: predict or update, forward or inverse.
- Adds boundary mirroring, valid/ready flow control, a sideband tag, and optional output saturation with an event counter.
- Sits between the row/column sample sequencer and the coefficient store in the DWT datapath.

---
 rtl/lift_step_pipe.sv | 127 ++++++++++++
 tb/tb_lift_step_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_step_pipe.sv
// Two-stage pipelined Le Gall 5/3 lifting step with boundary mirroring,
// valid/ready flow control, a sideband tag and optional output saturation.
module lift_step_pipe #(
  parameter int W     = 9,
  parameter int OUT_W = 10,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     left_i,
  input  logic signed [W-1:0]     sam_i,
  input  logic signed [W-1:0]     right_i,
  input  logic [1:0]              mode_i,
  input  logic [1:0]              edge_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] res_o,
  output logic [TAG_W-1:0]        tag_o,
  output logic                    sat_o,
  output logic [CNT_W-1:0]        sat_cnt_o
);

  localparam int SW = W + 1;
  localparam int XW = (OUT_W > W + 2) ? OUT_W : W + 2;
  localparam logic signed [XW-1:0] MAXV = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                 s1_valid, s2_valid;
  logic                 s1_adv, s2_adv;
  logic signed [SW-1:0] s1_sum;
  logic signed [W-1:0]  s1_sam;
  logic [1:0]           s1_mode;
  logic                 s1_pass;
  logic [TAG_W-1:0]     s1_tag;

  logic signed [W-1:0]  l_sel, r_sel;
  logic signed [SW-1:0] sum_c;

  logic signed [XW-1:0] sam_x, sum_x, rnd_x, half_x, quart_x, adj_x, r_x, rc_x;
  logic                 sat_c;

  // Handshake: a stage may advance when empty or when the stage after it drains.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
  end

  assign out_valid = s2_valid;

  // Edge mirroring and neighbour sum; both edges set means pass-through.
  always_comb begin
    l_sel = left_i;
    r_sel = right_i;
    case (edge_i)
      2'b01:   l_sel = right_i;
      2'b10:   r_sel = left_i;
      default: ;
    endcase
    if (edge_i == 2'b11) sum_c = '0;
    else                 sum_c = {l_sel[W-1], l_sel} + {r_sel[W-1], r_sel};
  end

  // Stage 1 register: sum, sample, mode, pass flag and tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_sam   <= '0;
      s1_mode  <= '0;
      s1_pass  <= 1'b0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum  <= sum_c;
        s1_sam  <= sam_i;
        s1_mode <= mode_i;
        s1_pass <= (edge_i == 2'b11);
        s1_tag  <= tag_i;
      end
    end
  end

  // Lift arithmetic (arithmetic shifts floor) followed by the output clamp.
  always_comb begin
    sam_x   = {{(XW-W){s1_sam[W-1]}}, s1_sam};
    sum_x   = {{(XW-SW){s1_sum[SW-1]}}, s1_sum};
    rnd_x   = sum_x + XW'(2);
    half_x  = sum_x >>> 1;
    quart_x = rnd_x >>> 2;
    adj_x   = s1_mode[0] ? quart_x : half_x;
    // Forward update and inverse predict add; the other two subtract.
    if (s1_pass)                     r_x = sam_x;
    else if (s1_mode[0] ^ s1_mode[1]) r_x = sam_x + adj_x;
    else                             r_x = sam_x - adj_x;
    // Clamp is inert when the result range already fits OUT_W.
    if (r_x > MAXV)      rc_x = MAXV;
    else if (r_x < MINV) rc_x = MINV;
    else                 rc_x = r_x;
    sat_c = (rc_x != r_x);
  end

  // Stage 2 register: result, tag, clamp flag and saturation event counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      res_o     <= '0;
      tag_o     <= '0;
      sat_o     <= 1'b0;
      sat_cnt_o <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        res_o <= rc_x[OUT_W-1:0];
        tag_o <= s1_tag;
        sat_o <= sat_c;
        if (sat_c && (sat_cnt_o != '1)) sat_cnt_o <= sat_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lift_step_pipe.sv
// Bench for lift_step_pipe: a default instance and a narrow-output instance
// (OUT_W=8, CNT_W=3) share stimulus and out_ready.
module tb_lift_step_pipe;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic signed [8:0] left_i, sam_i, right_i;
  logic [1:0]        mode_i, edge_i;
  logic [7:0]        tag_i;
  logic              out_ready;

  logic              in_ready_a, out_valid_a, sat_a;
  logic signed [9:0] res_a;
  logic [7:0]        tag_a;
  logic [15:0]       cnt_a;

  logic              in_ready_b, out_valid_b, sat_b;
  logic signed [7:0] res_b;
  logic [7:0]        tag_b;
  logic [2:0]        cnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lift_step_pipe dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .left_i(left_i), .sam_i(sam_i), .right_i(right_i), .mode_i(mode_i),
    .edge_i(edge_i), .tag_i(tag_i), .out_valid(out_valid_a), .out_ready(out_ready),
    .res_o(res_a), .tag_o(tag_a), .sat_o(sat_a), .sat_cnt_o(cnt_a)
  );

  lift_step_pipe #(.W(9), .OUT_W(8), .TAG_W(8), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .left_i(left_i), .sam_i(sam_i), .right_i(right_i), .mode_i(mode_i),
    .edge_i(edge_i), .tag_i(tag_i), .out_valid(out_valid_b), .out_ready(out_ready),
    .res_o(res_b), .tag_o(tag_b), .sat_o(sat_b), .sat_cnt_o(cnt_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Floor division for positive divisor.
  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // 5/3 lifting from first principles, unbounded integer result.
  function automatic int lift(input int l, input int s, input int r,
                              input logic [1:0] m, input logic [1:0] e);
    int lv, rv, sum, d;
    if (e == 2'b11) return s;
    lv = (e == 2'b01) ? r : l;
    rv = (e == 2'b10) ? l : r;
    sum = lv + rv;
    d = m[0] ? fdiv(sum + 2, 4) : fdiv(sum, 2);
    return (m == 2'b01 || m == 2'b10) ? s + d : s - d;
  endfunction

  function automatic int clampv(input int v, input int ow);
    int hi, lo;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  typedef struct {
    int l, s, r;
    logic [1:0] m, e;
    int t;
    int exp_a, exp_b, sat_exp_b;
  } vec_t;

  typedef struct {
    int ra, rb, sb, t;
  } exp_t;

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Present one sample, return 1 ns after the edge that accepts it.
  task automatic put(input int l, input int s, input int r, input logic [1:0] m,
                     input logic [1:0] e, input int t);
    bit rdy;
    left_i = 9'(l); sam_i = 9'(s); right_i = 9'(r);
    mode_i = m; edge_i = e; tag_i = 8'(t);
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rdy = in_ready_a;
      @(posedge clk); #1;
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("put_accept_timeout", 0, 1);
  endtask

  vec_t vt[11];
  exp_t q[$];

  initial begin
    int acc, got, nsat, stable_res, stable_tag;
    bit rdy, gap, held;
    exp_t x;

    out_ready = 1'b1;
    left_i = '0; sam_i = '0; right_i = '0; mode_i = '0; edge_i = '0; tag_i = '0;
    in_valid = 1'b0;

    vt[0]  = '{10, 20, 14, 2'b00, 2'b00, 8'h5A, 8, 8, 0};
    vt[1]  = '{6, 5, 7, 2'b01, 2'b00, 1, 8, 8, 0};
    vt[2]  = '{6, 8, 7, 2'b11, 2'b00, 2, 5, 5, 0};
    vt[3]  = '{99, 20, 14, 2'b00, 2'b01, 3, 6, 6, 0};
    vt[4]  = '{100, -37, 50, 2'b00, 2'b11, 4, -37, -37, 0};
    vt[5]  = '{-256, 255, -256, 2'b00, 2'b00, 5, 511, 127, 1};
    vt[6]  = '{-256, -256, -256, 2'b10, 2'b00, 6, -512, -128, 1};
    vt[7]  = '{-3, 0, 100, 2'b00, 2'b10, 7, 3, 3, 0};
    vt[8]  = '{-1, 0, 0, 2'b00, 2'b00, 8, 1, 1, 0};
    vt[9]  = '{-5, 10, -4, 2'b01, 2'b00, 9, 8, 8, 0};
    vt[10] = '{-5, 8, -4, 2'b11, 2'b00, 10, 10, 10, 0};

    // Reset state.
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_res", int'(res_a), 0);
    chk("rst_tag", int'(tag_a), 0);
    chk("rst_sat", int'(sat_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_in_ready", int'(in_ready_a), 1);
    @(posedge clk); #1;

    // Table of single samples with exact latency.
    for (int i = 0; i < 11; i++) begin
      put(vt[i].l, vt[i].s, vt[i].r, vt[i].m, vt[i].e, vt[i].t);
      @(negedge clk);
      chk($sformatf("vec%0d_early_valid", i), int'(out_valid_a), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), int'(out_valid_a), 1);
      chk($sformatf("vec%0d_res_a", i), int'(res_a), vt[i].exp_a);
      chk($sformatf("vec%0d_tag_a", i), int'(tag_a), vt[i].t);
      chk($sformatf("vec%0d_sat_a", i), int'(sat_a), 0);
      chk($sformatf("vec%0d_res_b", i), int'(res_b), vt[i].exp_b);
      chk($sformatf("vec%0d_sat_b", i), int'(sat_b), vt[i].sat_exp_b);
      @(posedge clk); #1;
    end
    chk("table_cnt_b", int'(cnt_b), 2);

    // Backpressure: four pass-through samples against a stalled sink.
    do_reset();
    out_ready = 1'b0;
    acc = 0;
    edge_i = 2'b11; mode_i = 2'b00;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; sam_i = 9'(acc + 1); tag_i = 8'(acc + 1);
      @(negedge clk);
      rdy = in_ready_a;
      @(posedge clk); #1;
      if (rdy) acc++;
    end
    chk("bp_accepts", acc, 2);
    @(negedge clk);
    chk("bp_in_ready_low", int'(in_ready_a), 0);
    @(posedge clk); #1;
    sam_i = 9'(acc + 1); tag_i = 8'(acc + 1);
    out_ready = 1'b1;
    got = 0; gap = 1'b0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      @(negedge clk);
      if (out_valid_a) begin
        chk("bp_order_res", int'(res_a), got + 1);
        chk("bp_order_tag", int'(tag_a), got + 1);
        got++;
      end else if (got > 0) gap = 1'b1;
      rdy = in_ready_a;
      @(posedge clk); #1;
      if (rdy && in_valid) acc++;
      sam_i = 9'(acc + 1); tag_i = 8'(acc + 1);
      if (acc == 4) in_valid = 1'b0;
    end
    chk("bp_count", got, 4);
    chk("bp_no_gap", int'(gap), 0);
    @(negedge clk);
    chk("bp_no_dup", int'(out_valid_a), 0);
    @(posedge clk); #1;

    // Saturation event counted once despite a long stall.
    do_reset();
    out_ready = 1'b0;
    put(-256, 255, -256, 2'b00, 2'b00, 8'h33);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sat_valid_b", int'(out_valid_b), 1);
    chk("sat_res_b", int'(res_b), 127);
    chk("sat_flag_b", int'(sat_b), 1);
    chk("sat_cnt_b", int'(cnt_b), 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("sat_stall_cnt_b", int'(cnt_b), 1);
      chk("sat_stall_res_b", int'(res_b), 127);
      chk("sat_stall_tag_b", int'(tag_b), 8'h33);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sat_drained", int'(out_valid_b), 0);
    @(posedge clk); #1;

    // Reset with two samples in flight.
    do_reset();
    out_ready = 1'b0;
    put(-256, 255, -256, 2'b00, 2'b00, 1);
    put(1, 2, 3, 2'b00, 2'b00, 2);
    @(negedge clk);
    chk("mid_pre_cnt_b", int'(cnt_b), 1);
    do_reset();
    @(negedge clk);
    chk("mid_out_valid", int'(out_valid_a), 0);
    chk("mid_res", int'(res_a), 0);
    chk("mid_cnt_b", int'(cnt_b), 0);
    chk("mid_in_ready", int'(in_ready_a), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    put(10, 20, 14, 2'b00, 2'b00, 8'h5A);
    @(negedge clk);
    chk("mid_early_valid", int'(out_valid_a), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_valid", int'(out_valid_a), 1);
    chk("mid_res_after", int'(res_a), 8);
    @(posedge clk); #1;

    // Random traffic against the reference model.
    do_reset();
    nsat = 0; held = 1'b0; stable_res = 0; stable_tag = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = (c < 500) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0) || (c >= 500);
      left_i  = 9'($urandom_range(0, 511));
      sam_i   = 9'($urandom_range(0, 511));
      right_i = 9'($urandom_range(0, 511));
      mode_i  = 2'($urandom_range(0, 3));
      edge_i  = 2'($urandom_range(0, 3));
      tag_i   = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (held) begin
        chk("rnd_hold_res", int'(res_a), stable_res);
        chk("rnd_hold_tag", int'(tag_a), stable_tag);
      end
      if (out_valid_a && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious_output", 1, 0);
        else begin
          x = q.pop_front();
          chk("rnd_res_a", int'(res_a), x.ra);
          chk("rnd_res_b", int'(res_b), x.rb);
          chk("rnd_sat_b", int'(sat_b), x.sb);
          chk("rnd_tag", int'(tag_a), x.t);
        end
      end
      if (in_valid && in_ready_a) begin
        x.ra = lift(int'(left_i), int'(sam_i), int'(right_i), mode_i, edge_i);
        x.rb = clampv(x.ra, 8);
        x.sb = (x.rb != x.ra) ? 1 : 0;
        x.ra = clampv(x.ra, 10);
        x.t  = int'(tag_i);
        nsat += x.sb;
        q.push_back(x);
      end
      held = out_valid_a && !out_ready;
      stable_res = int'(res_a);
      stable_tag = int'(tag_a);
      @(posedge clk); #1;
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_cnt_b_sticky", int'(cnt_b), (nsat > 7) ? 7 : nsat);
    chk("rnd_cnt_a", int'(cnt_a), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
